// File: rtl/multi_cycle_seq_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the
// datapath plus shared instruction/data memory.
interface multi_cycle_seq_if #(
  parameter int CNT_W = 16
);
  // Inputs to the sequencer
  logic             run;
  logic [6:0]       opCode;
  logic             mem_ack;
  // Outputs from the sequencer
  logic             mem_req;
  logic             ir_ld;
  logic             pc_en;
  logic             wr_en;
  logic             m_wr_en;
  logic [2:0]       alu_op;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] instr_cnt;

  // Sequencer side: issues memory requests and datapath strobes
  modport master (
    input  run, opCode, mem_ack,
    output mem_req, ir_ld, pc_en, wr_en, m_wr_en, alu_op,
           halted, timeout_err, instr_cnt
  );

  // Datapath/memory side
  modport slave (
    output run, opCode, mem_ack,
    input  mem_req, ir_ld, pc_en, wr_en, m_wr_en, alu_op,
           halted, timeout_err, instr_cnt
  );
endinterface

// File: rtl/multi_cycle_seq.sv
// Multi-cycle sequencer for the ten-instruction CPU. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB); strobes are decoded from the
// current state, the latched opcode and mem_ack. A memory request that waits
// TIMEOUT cycles without ack halts the machine with a sticky error flag.
module multi_cycle_seq #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_cycle_seq_if.master bus
);

  localparam logic [6:0] OP_ADD   = 7'b0000001;
  localparam logic [6:0] OP_STORE = 7'b0000010;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_HALT  = 7'b1111111;

  // Last wait count still allowed before the request is declared dead
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic       is_add;
  logic       is_store;
  logic       is_load;
  logic       retire;
  logic [2:0] alu_sel;

  // Class of the latched instruction and the ALU function it selects
  always_comb begin
    is_add   = (op_q == OP_ADD);
    is_store = (op_q == OP_STORE);
    is_load  = (op_q == OP_LOAD);
    if (is_add)
      alu_sel = 3'b001;
    else if (is_store || is_load)
      alu_sel = 3'b010;
    else
      alu_sel = 3'b000;
  end

  // Next-state, wait counter, retire and timeout decisions
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_cnt_d    = wait_cnt_q;
    instr_cnt_d   = instr_cnt_q;
    timeout_err_d = timeout_err_q;
    retire        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d    = S_FETCH;
          wait_cnt_d = '0;
        end
      end
      S_FETCH, S_MEM: begin
        // An ack in the final allowed cycle still completes the transfer
        if (bus.mem_ack) begin
          wait_cnt_d = '0;
          if (state_q == S_FETCH)
            state_d = S_DECODE;
          else if (is_store)
            retire = 1'b1;
          else
            state_d = S_WB;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = S_HALT;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d    = bus.opCode;
        state_d = (bus.opCode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_add) begin
          state_d = S_WB;
        end else if (is_store || is_load) begin
          state_d    = S_MEM;
          wait_cnt_d = '0;
        end else begin
          retire = 1'b1;
        end
      end
      S_WB: begin
        retire = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Instruction boundary: count it, then continue or park depending on run
    if (retire) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
      wait_cnt_d  = '0;
      state_d     = bus.run ? S_FETCH : S_IDLE;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      wait_cnt_q    <= '0;
      instr_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_cnt_q   <= instr_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Datapath strobes decoded from state, latched opcode and mem_ack
  always_comb begin
    bus.mem_req = (state_q == S_FETCH) || (state_q == S_MEM);
    bus.ir_ld   = (state_q == S_FETCH) && bus.mem_ack;
    bus.pc_en   = (state_q == S_FETCH) && bus.mem_ack;
    bus.wr_en   = (state_q == S_WB);
    bus.m_wr_en = (state_q == S_MEM) && is_store;
    bus.halted  = (state_q == S_HALT);
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
      bus.alu_op = alu_sel;
    else
      bus.alu_op = 3'b000;
  end

  assign bus.timeout_err = timeout_err_q;
  assign bus.instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Directed testbench for multi_cycle_seq: reset, a full program, stalled
// fetch, MEM timeout and its last-cycle rescue, run drop, counter wrap.
`timescale 1ns/1ps
module tb_multi_cycle_seq;

  localparam logic [6:0] OP_ADD   = 7'h01;
  localparam logic [6:0] OP_STORE = 7'h02;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_NOP   = 7'h10;
  localparam logic [6:0] OP_HALT  = 7'h7F;

  // Strobe vector: {mem_req, ir_ld, pc_en, wr_en, m_wr_en, alu_op[2:0], halted}
  localparam logic [8:0] ST_IDLE   = 9'b0_0_0_0_0_000_0;
  localparam logic [8:0] ST_FE     = 9'b1_1_1_0_0_000_0;
  localparam logic [8:0] ST_REQ    = 9'b1_0_0_0_0_000_0;
  localparam logic [8:0] ST_EX_ADD = 9'b0_0_0_0_0_001_0;
  localparam logic [8:0] ST_WB_ADD = 9'b0_0_0_1_0_001_0;
  localparam logic [8:0] ST_EX_LS  = 9'b0_0_0_0_0_010_0;
  localparam logic [8:0] ST_MEM_ST = 9'b1_0_0_0_1_010_0;
  localparam logic [8:0] ST_MEM_LD = 9'b1_0_0_0_0_010_0;
  localparam logic [8:0] ST_WB_LD  = 9'b0_0_0_1_0_010_0;
  localparam logic [8:0] ST_HLT    = 9'b0_0_0_0_0_000_1;

  logic clk;
  logic rst_n;
  logic rst4_n;

  int checks;
  int errors;

  multi_cycle_seq_if #(.CNT_W(16)) bus ();
  multi_cycle_seq_if #(.CNT_W(4))  bus4 ();

  multi_cycle_seq #(.CNT_W(16), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multi_cycle_seq #(.CNT_W(4), .TIMEOUT(15)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {bus.mem_req, bus.ir_ld, bus.pc_en, bus.wr_en, bus.m_wr_en,
            bus.alu_op, bus.halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset mid-cycle and confirm the cleared state
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_strobes", 32'(strobes()), 32'(ST_IDLE));
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    check("rst_cnt", 32'(bus.instr_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  logic [6:0] t_op  [19];
  logic [8:0] t_st  [19];
  int         t_cnt [19];

  initial begin
    int wr_cnt;
    int mwr_cnt;
    int req_cycles;
    int ir_cycles;

    checks = 0;
    errors = 0;

    t_op  = '{OP_ADD, OP_ADD, OP_ADD, OP_ADD,
              OP_STORE, OP_STORE, OP_STORE, OP_STORE,
              OP_LOAD, OP_LOAD, OP_LOAD, OP_LOAD, OP_LOAD,
              OP_NOP, OP_NOP, OP_NOP,
              OP_HALT, OP_HALT, OP_HALT};
    t_st  = '{ST_FE, ST_IDLE, ST_EX_ADD, ST_WB_ADD,
              ST_FE, ST_IDLE, ST_EX_LS, ST_MEM_ST,
              ST_FE, ST_IDLE, ST_EX_LS, ST_MEM_LD, ST_WB_LD,
              ST_FE, ST_IDLE, ST_IDLE,
              ST_FE, ST_IDLE, ST_HLT};
    t_cnt = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 4, 4, 4};

    rst_n        = 1'b0;
    rst4_n       = 1'b0;
    bus.run      = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.opCode   = '0;
    bus4.run     = 1'b0;
    bus4.mem_ack = 1'b0;
    bus4.opCode  = '0;

    // ---- Test 1: reset state, async reset mid-MEM of a STORE ----
    #1;
    check("t1_reset_strobes", 32'(strobes()), 32'(ST_IDLE));
    check("t1_reset_cnt", 32'(bus.instr_cnt), 32'd0);
    check("t1_reset_terr", 32'(bus.timeout_err), 32'd0);
    tick();
    rst_n       = 1'b1;
    bus.run     = 1'b1;
    bus.mem_ack = 1'b1;
    bus.opCode  = OP_STORE;
    tick(); #1;
    check("t1_fetch", 32'(strobes()), 32'(ST_FE));
    tick(); #1;
    check("t1_decode", 32'(strobes()), 32'(ST_IDLE));
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("t1_exec", 32'(strobes()), 32'(ST_EX_LS));
    tick(); #1;
    check("t1_mem", 32'(strobes()), 32'(ST_MEM_ST));
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_async_strobes", 32'(strobes()), 32'(ST_IDLE));
    check("t1_async_cnt", 32'(bus.instr_cnt), 32'd0);
    #2;
    rst_n       = 1'b1;
    bus.mem_ack = 1'b1;
    #1;
    check("t1_idle_after_rel", 32'(strobes()), 32'(ST_IDLE));
    tick(); #1;
    check("t1_fetch_after_rel", 32'(strobes()), 32'(ST_FE));
    check("t1_cnt_after_rel", 32'(bus.instr_cnt), 32'd0);
    $display("t1 async reset mid-MEM done");

    // ---- Test 2: ADD, STORE, LOAD, NOP, HALT with ack tied high ----
    tick();
    do_reset();
    bus.run     = 1'b1;
    bus.mem_ack = 1'b1;
    wr_cnt  = 0;
    mwr_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      bus.opCode = t_op[i];
      #1;
      check($sformatf("t2_row%0d_strobes", i), 32'(strobes()), 32'(t_st[i]));
      check($sformatf("t2_row%0d_cnt", i), 32'(bus.instr_cnt), 32'(t_cnt[i]));
      wr_cnt  += int'(bus.wr_en);
      mwr_cnt += int'(bus.m_wr_en);
      $display("t2 row %0d op=%h strobes=%b cnt=%0d", i, t_op[i], strobes(), bus.instr_cnt);
    end
    check("t2_wr_pulses", 32'(wr_cnt), 32'd2);
    check("t2_mwr_pulses", 32'(mwr_cnt), 32'd1);
    check("t2_terr", 32'(bus.timeout_err), 32'd0);
    bus.run = 1'b0;
    repeat (2) tick();
    bus.run = 1'b1;
    repeat (2) tick();
    #1;
    check("t2_halt_terminal", 32'(strobes()), 32'(ST_HLT));
    check("t2_halt_cnt", 32'(bus.instr_cnt), 32'd4);

    // ---- Test 3: fetch ack delayed 5 cycles ----
    tick();
    do_reset();
    bus.run     = 1'b1;
    bus.mem_ack = 1'b0;
    bus.opCode  = OP_NOP;
    req_cycles  = 0;
    ir_cycles   = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.mem_ack = (i == 5);
      #1;
      check($sformatf("t3_wait%0d", i), 32'(strobes()), (i == 5) ? 32'(ST_FE) : 32'(ST_REQ));
      req_cycles += int'(bus.mem_req);
      ir_cycles  += int'(bus.ir_ld);
      $display("t3 fetch cycle %0d ack=%b strobes=%b", i, bus.mem_ack, strobes());
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("t3_decode", 32'(strobes()), 32'(ST_IDLE));
    check("t3_req_cycles", 32'(req_cycles), 32'd6);
    check("t3_ir_cycles", 32'(ir_cycles), 32'd1);

    // ---- Test 4a: LOAD with mem_ack stuck low in MEM ----
    tick();
    do_reset();
    bus.run     = 1'b1;
    bus.mem_ack = 1'b1;
    bus.opCode  = OP_LOAD;
    tick();
    tick();
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("t4a_exec", 32'(strobes()), 32'(ST_EX_LS));
    wr_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      tick(); #1;
      check($sformatf("t4a_mem%0d", i), 32'(strobes()), 32'(ST_MEM_LD));
      wr_cnt += int'(bus.wr_en);
    end
    tick(); #1;
    check("t4a_halt", 32'(strobes()), 32'(ST_HLT));
    check("t4a_terr", 32'(bus.timeout_err), 32'd1);
    check("t4a_cnt", 32'(bus.instr_cnt), 32'd0);
    tick();
    bus.mem_ack = 1'b1;
    #1;
    wr_cnt += int'(bus.wr_en);
    check("t4a_halt_ack_ignored", 32'(strobes()), 32'(ST_HLT));
    check("t4a_no_wr", 32'(wr_cnt), 32'd0);
    $display("t4a timeout halt terr=%b", bus.timeout_err);

    // ---- Test 4b: ack arrives on the 15th request cycle ----
    tick();
    do_reset();
    bus.run     = 1'b1;
    bus.mem_ack = 1'b1;
    bus.opCode  = OP_LOAD;
    tick();
    tick();
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      bus.mem_ack = (i == 15);
      #1;
      check($sformatf("t4b_mem%0d", i), 32'(strobes()), 32'(ST_MEM_LD));
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("t4b_wb", 32'(strobes()), 32'(ST_WB_LD));
    check("t4b_terr_wb", 32'(bus.timeout_err), 32'd0);
    tick(); #1;
    check("t4b_next_fetch", 32'(strobes()), 32'(ST_REQ));
    check("t4b_cnt", 32'(bus.instr_cnt), 32'd1);
    check("t4b_terr", 32'(bus.timeout_err), 32'd0);
    $display("t4b last-cycle ack rescued, cnt=%0d", bus.instr_cnt);

    // ---- Test 5: run dropped during EXEC of ADD ----
    tick();
    do_reset();
    bus.run     = 1'b1;
    bus.mem_ack = 1'b1;
    bus.opCode  = OP_ADD;
    tick(); #1;
    check("t5_fetch", 32'(strobes()), 32'(ST_FE));
    tick();
    tick();
    bus.run = 1'b0;
    #1;
    check("t5_exec", 32'(strobes()), 32'(ST_EX_ADD));
    tick(); #1;
    check("t5_wb", 32'(strobes()), 32'(ST_WB_ADD));
    check("t5_wb_cnt", 32'(bus.instr_cnt), 32'd0);
    tick(); #1;
    check("t5_idle", 32'(strobes()), 32'(ST_IDLE));
    check("t5_cnt", 32'(bus.instr_cnt), 32'd1);
    tick(); #1;
    check("t5_idle_stays", 32'(strobes()), 32'(ST_IDLE));
    bus.run = 1'b1;
    tick(); #1;
    check("t5_refetch", 32'(strobes()), 32'(ST_FE));
    $display("t5 run drop completed ADD, cnt=%0d", bus.instr_cnt);

    // ---- Test 6: 4-bit counter wraps after 16 NOPs ----
    bus4.run     = 1'b1;
    bus4.mem_ack = 1'b1;
    bus4.opCode  = OP_NOP;
    rst4_n       = 1'b1;
    tick(); #1;
    check("t6_start_cnt", 32'(bus4.instr_cnt), 32'd0);
    check("t6_start_fetch", 32'(bus4.mem_req), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      repeat (3) tick();
      #1;
      check($sformatf("t6_nop%0d_cnt", k), 32'(bus4.instr_cnt), 32'(k % 16));
      $display("t6 nop %0d retired cnt=%0d", k, bus4.instr_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_seq.md
Name: multi_cycle_seq

Overview:
Multi-cycle sequencer for the ten-instruction CPU. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath strobes (ir_ld, pc_en, wr_en, m_wr_en, alu_op) plus a req/ack handshake to the shared instruction/data memory. It replaces purely combinational opcode decode with a timed control sequence, and adds a retired-instruction counter and an ack-timeout halt.

Parameters:
CNT_W, 16, width of retired-instruction counter
TIMEOUT, 15, max cycles mem_req may wait for mem_ack before error halt (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  enable; sampled at IDLE and at instruction boundaries
opCode  input  7  instruction opcode from IR; valid from DECODE onward
mem_ack  input  1  memory accepted/completed current request this cycle
mem_req  output  1  memory request (fetch or data)
ir_ld  output  1  load IR from memory read data
pc_en  output  1  increment PC
wr_en  output  1  register-file write strobe
m_wr_en  output  1  memory write (qualifies mem_req)
alu_op  output  3  ALU function select
halted  output  1  sequencer in HALT
timeout_err  output  1  sticky: HALT was entered by ack timeout
instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset is asynchronous on rst_n low:
  - State goes to IDLE; op_q, wait_cnt, instr_cnt and timeout_err clear to 0.
  - All outputs are 0.
- Opcode classes:
  - 0000001 ADD: alu_op 001.
  - 0000010 STORE: alu_op 010.
  - 0000011 LOAD: alu_op 010.
  - 1111111 HALT.
  - Any other value: NOP, alu_op 000.
- State transitions:
  - IDLE: if run=1, go to FETCH next cycle; otherwise stay.
  - FETCH: mem_req=1, m_wr_en=0. If mem_ack=1 in the same cycle, ir_ld=1 and pc_en=1 for exactly that cycle, then go to DECODE.
  - DECODE: op_q<=opCode (single cycle). If opCode=HALT, go to HALT; else go to EXEC. HALT does not increment instr_cnt.
  - EXEC: alu_op from op_q (single cycle).
    - ADD goes to WB.
    - LOAD and STORE go to MEM.
    - NOP retires and goes to boundary.
  - MEM: mem_req=1, m_wr_en=1 if STORE; alu_op is held.
    - On mem_ack, STORE retires and goes to boundary.
    - On mem_ack, LOAD goes to WB.
  - WB: wr_en=1 and alu_op held for one cycle; the instruction retires and goes to boundary.
  - HALT: halted=1 and all strobes 0. The state is terminal; only rst_n exits it, and run is ignored.
- Boundary: instr_cnt increments on the retire cycle. Next state is FETCH if run=1, else IDLE. Deasserting run mid-instruction never aborts that instruction.
- Output timing:
  - Strobes are combinational from state, op_q and mem_ack.
  - wr_en and m_wr_en are never both 1.
  - ir_ld and pc_en are single-cycle pulses.
- alu_op outside EXEC/MEM/WB is 000.
- Handshake: mem_req stays high until the cycle where mem_ack=1. mem_ack is ignored outside FETCH/MEM.
- wait_cnt:
  - Clears on entry to FETCH/MEM and on mem_ack.
  - Increments each FETCH/MEM cycle with mem_ack=0.
  - When wait_cnt=TIMEOUT-1 with mem_ack=0, the next state is HALT and timeout_err<=1.
  - mem_ack arriving in that same cycle wins: the transfer completes and there is no error.
- instr_cnt wraps from 2^CNT_W-1 to 0.
- Minimum latency with mem_ack tied high:
  - ADD: 4 cycles.
  - STORE/NOP: 4/3 cycles.
  - LOAD: 5 cycles.

Test Plan:
1. rst_n low mid-MEM of a STORE -> all outputs 0 in the same cycle (async). After release with run=1, FETCH is reached 1 cycle later and instr_cnt=0.
2. run=1, mem_ack=1 constantly, program ADD,STORE,LOAD,NOP, then opCode=HALT on the 5th fetch:
   - wr_en pulses exactly twice (ADD WB, LOAD WB) and m_wr_en exactly once.
   - alu_op sequence across EXEC states is 001,010,010,000.
   - instr_cnt=4, then halted=1, timeout_err=0.
3. FETCH with mem_ack delayed 5 cycles -> mem_req held 6 cycles, and ir_ld/pc_en high only on the ack cycle.
4. TIMEOUT=15, mem_ack stuck 0 in MEM of LOAD -> HALT after 15 request cycles, timeout_err=1, wr_en never asserted. A second run with ack on cycle 15 gives no error.
5. run dropped during EXEC of ADD -> WB still completes (wr_en=1), instr_cnt+1, then IDLE with no mem_req. Reassert run -> FETCH.
6. CNT_W=4, 16 NOPs retired -> instr_cnt wraps 15->0.
